uart_baud_ctrl: RTL and testbench
=================================

Name: uart_baud_ctrl

Overview:
Divisor-latch controller and tick scheduler for the UART baud-rate generator.
- Holds the software-visible 16-bit divisor latch, written bytewise from the APB register block.
- Commits a new divisor to the generator only when TX and RX are idle, and restarts the generator cleanly.
- Divides the 16x oversample tick into a TX bit tick and an RX mid-bit sample tick, shared by the TX and RX engines.

Parameters:
DIV_W, 16, divisor width (matches generator divisor port)
OVS, 16, oversample ratio, power of two, >= 4
OVS_W, 4, log2(OVS), oversample counter width

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous reset, active-high
wr_dll_i  in  1  write strobe, divisor low byte
wr_dlm_i  in  1  write strobe, divisor high byte
wdata_i  in  8  write data
dl_o  out  DIV_W  shadow latch readback for register block
update_pending_o  out  1  shadow differs from committed, commit not yet done
brg_divisor_o  out  DIV_W  committed divisor to generator
brg_enable_o  out  1  generator reload/hold strobe
brg_tick_i  in  1  oversample tick from generator (1-cycle pulse)
tx_busy_i  in  1  TX engine mid-frame
rx_busy_i  in  1  RX engine mid-frame
rx_start_i  in  1  RX start-bit falling edge detected (1-cycle pulse)
tx_bit_tick_o  out  1  one pulse per OVS oversample ticks
rx_sample_tick_o  out  1  mid-bit sample pulse, phase-aligned to rx_start_i

Behaviour:
Reset (async, immediate):
- state=OFF; shadow=0; committed=0; pend=0; both OVS counters=0.
- tx_bit_tick_o=0; rx_sample_tick_o=0; brg_enable_o=1.

Shadow latch:
- wr_dll_i loads shadow[7:0] and wr_dlm_i loads shadow[15:8], both from wdata_i.
- Both strobes asserted in the same cycle load both bytes.
- Any write sets pend=1.
- Writes are accepted in every state.

FSM. brg_enable_o is a pure decode of the state register: 1 in OFF and LOAD, 0 otherwise.
- OFF: generator held, ticks ignored, counters held at 0. pend=1 -> LOAD.
- RUN: pend=1 -> WAIT_IDLE.
- WAIT_IDLE: ticks continue at the old divisor. tx_busy_i=0 and rx_busy_i=0 in the same cycle -> LOAD. Further writes update shadow; state is unchanged.
- LOAD (exactly 1 cycle):
  - committed<=shadow; both OVS counters<=0.
  - pend<=0, unless a write occurs in this same cycle, in which case pend stays 1 and a second commit follows via RUN/WAIT_IDLE.
  - Next state: OFF if the committed value is 0, else RUN.
- brg_divisor_o = committed register; it changes only on the clock edge that ends LOAD.
- update_pending_o = pend.

TX divider:
- In RUN/WAIT_IDLE, each brg_tick_i increments tx_ovs (wraps OVS-1 -> 0).
- The tick that wraps it pulses tx_bit_tick_o for 1 cycle on the following cycle (registered, latency 1).

RX divider:
- In RUN/WAIT_IDLE, each brg_tick_i increments rx_ovs (wraps OVS-1 -> 0).
- rx_start_i forces rx_ovs<=0 and has priority over a simultaneous brg_tick_i. That tick is consumed: no increment, no pulse.
- rx_sample_tick_o pulses 1 cycle after a brg_tick_i that advances rx_ovs from OVS/2-1 to OVS/2.
- rx_start_i is ignored in OFF and LOAD.

Other boundary rules:
- In LOAD and OFF, brg_tick_i is dropped; no output pulses are generated.
- A pulse already registered (from a tick in the last RUN/WAIT_IDLE cycle) still appears during LOAD.
- Reset mid-frame or mid-LOAD returns to OFF and discards the shadow value.

Test Plan:
1. From reset, write DLL=0x10, DLM=0x00 -> update_pending_o=1 for 1 cycle; LOAD next cycle with brg_enable_o=1; brg_divisor_o=0x0010; state RUN; brg_enable_o=0; update_pending_o=0.
2. RUN, drive brg_tick_i every 17 cycles for 48 ticks -> exactly 3 tx_bit_tick_o pulses, each 1 cycle after ticks 16, 32, 48.
3. RUN with tx_busy_i=1, write DLL=0x20 -> brg_divisor_o stays 0x0010 and ticks keep counting. Drop tx_busy_i -> LOAD next cycle; brg_divisor_o=0x0020; tx_ovs=0.
4. rx_start_i coincident with brg_tick_i, then 8 further ticks -> no pulse on the coincident tick; rx_sample_tick_o exactly once, 1 cycle after the 8th tick. Repeat with OVS=8: pulse after the 4th tick.
5. Write DLL=0x00, DLM=0x00 while idle -> LOAD then OFF; brg_enable_o=1; 20 brg_tick_i pulses produce no tx/rx ticks.
6. Write during the LOAD cycle -> pend stays 1 and a second LOAD occurs. Assert rst_i asynchronously mid-frame -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/uart_baud_ctrl.sv
// Divisor latch and tick scheduler for the UART baud-rate generator: bytewise shadow latch,
// idle-gated commit FSM and the TX bit / RX mid-bit dividers of the oversample tick.
module uart_baud_ctrl #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned OVS   = 16,
    parameter int unsigned OVS_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_dll_i,
    input  logic             wr_dlm_i,
    input  logic [7:0]       wdata_i,
    output logic [DIV_W-1:0] dl_o,
    output logic             update_pending_o,
    output logic [DIV_W-1:0] brg_divisor_o,
    output logic             brg_enable_o,
    input  logic             brg_tick_i,
    input  logic             tx_busy_i,
    input  logic             rx_busy_i,
    input  logic             rx_start_i,
    output logic             tx_bit_tick_o,
    output logic             rx_sample_tick_o
);

    typedef enum logic [1:0] {StOff, StRun, StWaitIdle, StLoad} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  shadow_q, shadow_d;
    logic [DIV_W-1:0]  committed_q, committed_d;
    logic              pend_q, pend_d;
    logic [OVS_W-1:0]  tx_ovs_q, tx_ovs_d;
    logic [OVS_W-1:0]  rx_ovs_q, rx_ovs_d;
    logic              tx_bit_q, tx_bit_d;
    logic              rx_smp_q, rx_smp_d;

    logic wr;
    logic active;
    logic tx_wrap;
    logic rx_mid;

    assign wr      = wr_dll_i | wr_dlm_i;
    assign active  = (state_q == StRun) || (state_q == StWaitIdle);
    assign tx_wrap = (tx_ovs_q == OVS_W'(OVS - 1));
    assign rx_mid  = (rx_ovs_q == OVS_W'(OVS / 2 - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StOff:      if (pend_q) state_d = StLoad;
            StRun:      if (pend_q) state_d = StWaitIdle;
            StWaitIdle: if (!tx_busy_i && !rx_busy_i) state_d = StLoad;
            // A zero divisor parks the generator instead of running it.
            StLoad:     state_d = (shadow_q == '0) ? StOff : StRun;
            default:    state_d = StOff;
        endcase
    end

    always_comb begin
        shadow_d    = shadow_q;
        committed_d = committed_q;
        pend_d      = pend_q;
        if (wr_dll_i) shadow_d[7:0]  = wdata_i;
        if (wr_dlm_i) shadow_d[15:8] = wdata_i;
        if (state_q == StLoad) begin
            committed_d = shadow_q;
            pend_d      = wr;
        end else if (wr) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        tx_ovs_d = tx_ovs_q;
        rx_ovs_d = rx_ovs_q;
        tx_bit_d = 1'b0;
        rx_smp_d = 1'b0;
        if (state_q == StLoad) begin
            tx_ovs_d = '0;
            rx_ovs_d = '0;
        end else if (active) begin
            if (brg_tick_i) begin
                tx_ovs_d = tx_wrap ? '0 : tx_ovs_q + 1'b1;
                tx_bit_d = tx_wrap;
            end
            // A start edge realigns the RX phase and swallows a coincident tick.
            if (rx_start_i) begin
                rx_ovs_d = '0;
            end else if (brg_tick_i) begin
                rx_ovs_d = (rx_ovs_q == OVS_W'(OVS - 1)) ? '0 : rx_ovs_q + 1'b1;
                rx_smp_d = rx_mid;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StOff;
            shadow_q    <= '0;
            committed_q <= '0;
            pend_q      <= 1'b0;
            tx_ovs_q    <= '0;
            rx_ovs_q    <= '0;
            tx_bit_q    <= 1'b0;
            rx_smp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            committed_q <= committed_d;
            pend_q      <= pend_d;
            tx_ovs_q    <= tx_ovs_d;
            rx_ovs_q    <= rx_ovs_d;
            tx_bit_q    <= tx_bit_d;
            rx_smp_q    <= rx_smp_d;
        end
    end

    assign dl_o             = shadow_q;
    assign update_pending_o = pend_q;
    assign brg_divisor_o    = committed_q;
    assign brg_enable_o     = (state_q == StOff) || (state_q == StLoad);
    assign tx_bit_tick_o    = tx_bit_q;
    assign rx_sample_tick_o = rx_smp_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl; a second instance with OVS=8 shares all inputs.
module tb_uart_baud_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_dll = 1'b0;
    logic        wr_dlm = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        tick = 1'b0;
    logic        tx_busy = 1'b0;
    logic        rx_busy = 1'b0;
    logic        rx_start = 1'b0;

    logic [15:0] dl, div, dl8, div8;
    logic        pend, en, txt, rxs;
    logic        pend8, en8, txt8, rxs8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_baud_ctrl #(.DIV_W(16), .OVS(16), .OVS_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .wr_dll_i(wr_dll), .wr_dlm_i(wr_dlm), .wdata_i(wdata),
        .dl_o(dl), .update_pending_o(pend), .brg_divisor_o(div), .brg_enable_o(en),
        .brg_tick_i(tick), .tx_busy_i(tx_busy), .rx_busy_i(rx_busy), .rx_start_i(rx_start),
        .tx_bit_tick_o(txt), .rx_sample_tick_o(rxs)
    );

    uart_baud_ctrl #(.DIV_W(16), .OVS(8), .OVS_W(3)) dut8 (
        .clk_i(clk), .rst_i(rst), .wr_dll_i(wr_dll), .wr_dlm_i(wr_dlm), .wdata_i(wdata),
        .dl_o(dl8), .update_pending_o(pend8), .brg_divisor_o(div8), .brg_enable_o(en8),
        .brg_tick_i(tick), .tx_busy_i(tx_busy), .rx_busy_i(rx_busy), .rx_start_i(rx_start),
        .tx_bit_tick_o(txt8), .rx_sample_tick_o(rxs8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Tick sampled on the next edge; its registered pulse is visible on return.
    task automatic pulse_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    int n_tx, n_stray;

    initial begin
        // Reset state
        cycle();
        check("rst_en", en, 1);
        check("rst_div", div, 0);
        check("rst_dl", dl, 0);
        check("rst_pend", pend, 0);
        check("rst_txt", txt, 0);
        check("rst_rxs", rxs, 0);
        rst = 1'b0;
        cycle();

        // 1: program 0x0010 from OFF
        wr_dll = 1'b1; wdata = 8'h10;
        cycle();
        check("t1_pend", pend, 1);
        check("t1_dl", dl, 16'h0010);
        check("t1_en_off", en, 1);
        wr_dll = 1'b0; wr_dlm = 1'b1; wdata = 8'h00;
        cycle();
        wr_dlm = 1'b0;
        check("t1_en_load", en, 1);
        check("t1_div_hold", div, 0);
        cycle();
        check("t1_div", div, 16'h0010);
        check("t1_en_run", en, 0);
        check("t1_pend_clr", pend, 0);

        // 2: 48 ticks spaced 17 cycles -> tx pulses after ticks 16, 32, 48
        n_tx = 0; n_stray = 0;
        for (int i = 1; i <= 48; i++) begin
            pulse_tick();
            check($sformatf("t2_tx_%0d", i), {31'd0, txt}, {31'd0, (i % 16) == 0});
            if (txt) n_tx++;
            repeat (16) begin
                cycle();
                if (txt) n_stray++;
            end
        end
        check("t2_count", n_tx, 3);
        check("t2_stray", n_stray, 0);

        // 3: commit deferred while TX busy
        tx_busy = 1'b1; wr_dll = 1'b1; wdata = 8'h20;
        cycle();
        wr_dll = 1'b0;
        check("t3_pend", pend, 1);
        check("t3_dl", dl, 16'h0020);
        cycle();
        check("t3_div_wait", div, 16'h0010);
        check("t3_en_wait", en, 0);
        for (int i = 1; i <= 5; i++) begin
            pulse_tick();
            check($sformatf("t3_wait_tx_%0d", i), txt, 0);
            cycle();
        end
        check("t3_div_still", div, 16'h0010);
        tx_busy = 1'b0;
        cycle();
        check("t3_en_load", en, 1);
        check("t3_div_load", div, 16'h0010);
        cycle();
        check("t3_div", div, 16'h0020);
        check("t3_en_run", en, 0);
        check("t3_pend_clr", pend, 0);
        for (int i = 1; i <= 16; i++) begin
            pulse_tick();
            check($sformatf("t3_tx_%0d", i), {31'd0, txt}, {31'd0, i == 16});
            cycle();
        end

        // 4: rx_start realigns and consumes the coincident tick
        for (int i = 1; i <= 3; i++) begin
            pulse_tick();
            check($sformatf("t4_pre_rx_%0d", i), {rxs, rxs8}, 2'b00);
            cycle();
        end
        rx_start = 1'b1; tick = 1'b1;
        cycle();
        rx_start = 1'b0; tick = 1'b0;
        check("t4_coinc_rx16", rxs, 0);
        check("t4_coinc_rx8", rxs8, 0);
        cycle();
        for (int i = 1; i <= 8; i++) begin
            pulse_tick();
            check($sformatf("t4_rx16_%0d", i), {31'd0, rxs}, {31'd0, i == 8});
            check($sformatf("t4_rx8_%0d", i), {31'd0, rxs8}, {31'd0, i == 4});
            cycle();
        end

        // 5: zero divisor parks in OFF, both bytes in one write
        wr_dll = 1'b1; wr_dlm = 1'b1; wdata = 8'h00;
        cycle();
        wr_dll = 1'b0; wr_dlm = 1'b0;
        check("t5_dl", dl, 0);
        check("t5_pend", pend, 1);
        cycle();
        cycle();
        check("t5_en_load", en, 1);
        cycle();
        check("t5_div", div, 0);
        check("t5_en_off", en, 1);
        check("t5_pend_clr", pend, 0);
        n_stray = 0;
        for (int i = 1; i <= 20; i++) begin
            pulse_tick();
            if (txt || rxs || txt8 || rxs8) n_stray++;
            cycle();
            if (txt || rxs || txt8 || rxs8) n_stray++;
        end
        check("t5_no_pulses", n_stray, 0);
        check("t5_en_still", en, 1);

        // 6: write during LOAD forces a second commit
        wr_dll = 1'b1; wr_dlm = 1'b1; wdata = 8'h05;
        cycle();
        wr_dll = 1'b0; wr_dlm = 1'b0;
        check("t6_dl_both", dl, 16'h0505);
        cycle();
        check("t6_en_load1", en, 1);
        wr_dll = 1'b1; wdata = 8'h07;
        cycle();
        wr_dll = 1'b0;
        check("t6_div1", div, 16'h0505);
        check("t6_pend_kept", pend, 1);
        check("t6_en_run", en, 0);
        check("t6_dl2", dl, 16'h0507);
        cycle();
        cycle();
        check("t6_en_load2", en, 1);
        cycle();
        check("t6_div2", div, 16'h0507);
        check("t6_pend_clr", pend, 0);
        check("t6_en_run2", en, 0);

        // Async reset mid-frame with a pulse and a pending update in flight
        tx_busy = 1'b1;
        repeat (15) begin
            pulse_tick();
            cycle();
        end
        tick = 1'b1; wr_dll = 1'b1; wdata = 8'h99;
        cycle();
        tick = 1'b0; wr_dll = 1'b0;
        check("t6_pre_txt", txt, 1);
        check("t6_pre_pend", pend, 1);
        check("t6_pre_dl", dl, 16'h0599);
        #1 rst = 1'b1;
        #1;
        check("t6_arst_en", en, 1);
        check("t6_arst_div", div, 0);
        check("t6_arst_dl", dl, 0);
        check("t6_arst_pend", pend, 0);
        check("t6_arst_txt", txt, 0);
        check("t6_arst_rxs", rxs, 0);
        cycle();
        rst = 1'b0; tx_busy = 1'b0;
        cycle();
        cycle();
        check("t6_post_en", en, 1);
        check("t6_post_div", div, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
